// File: rtl/clock_wave_gen.sv
// Output stage of the clock chain: turns the upstream period count into clk_out
// with shadowed high-time config and burst/stop control. Optional macro: CLK_WAVE_SYNC_EN.
//
//   state    | meaning
//   IDLE     | output parked low, waiting for enable
//   ARMED    | enabled, waiting for the next period boundary to start
//   RUN      | generating waveform, counting periods
//   STOPPING | enable dropped, finishing the current period
module clock_wave_gen #(
    parameter int WIDTH   = 32,
    parameter int PULSE_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [WIDTH-1:0]   counter,
    input  logic               clear,
    input  logic [WIDTH-1:0]   cfg_high,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PULSE_W-1:0] burst_len,
    output logic               clk_out,
    output logic               period_tick,
    output logic               busy,
    output logic [PULSE_W-1:0] pulses_done,
    output logic               done
);
    typedef enum logic [1:0] {IDLE, ARMED, RUN, STOPPING} state_t;

    state_t             state, state_nxt;
    logic               en;
    logic [WIDTH-1:0]   shadow, active_high;
    logic               pending;
    logic [PULSE_W-1:0] burst_reg;
    logic [PULSE_W-1:0] pulses_inc;
    logic               burst_end;
    logic               load_cfg;
    logic               clk_out_nxt, tick_nxt, done_nxt;

`ifdef CLK_WAVE_SYNC_EN
    logic [1:0] en_sync;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) en_sync <= '0;
        else        en_sync <= {en_sync[0], enable};
    end
    assign en = en_sync[1];
`else
    assign en = enable;
`endif

    assign pulses_inc = pulses_done + PULSE_W'(1);
    assign burst_end  = (burst_reg != '0) && (pulses_inc == burst_reg);
    assign cfg_ready  = !pending;
    assign busy       = (state != IDLE);
    // A capture on a boundary cycle cannot also load: load needs pending already set.
    assign load_cfg   = clear && pending && ((state == ARMED) || (state == RUN));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (en) state_nxt = ARMED;
            ARMED: begin
                if (!en)        state_nxt = IDLE;
                else if (clear) state_nxt = RUN;
            end
            RUN: begin
                if (clear && burst_end) state_nxt = IDLE;
                else if (!en)           state_nxt = STOPPING;
            end
            STOPPING: begin
                if (clear)   state_nxt = IDLE;
                else if (en) state_nxt = RUN;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        clk_out_nxt = 1'b0;
        tick_nxt    = 1'b0;
        done_nxt    = 1'b0;
        if ((state == RUN) || (state == STOPPING)) begin
            clk_out_nxt = (counter < active_high);
            if (clear) begin
                tick_nxt = 1'b1;
                if ((state == STOPPING) || burst_end) begin
                    done_nxt    = 1'b1;
                    clk_out_nxt = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_out     <= 1'b0;
            period_tick <= 1'b0;
            done        <= 1'b0;
            pulses_done <= '0;
            burst_reg   <= '0;
            shadow      <= '0;
            active_high <= '0;
            pending     <= 1'b0;
        end else begin
            clk_out     <= clk_out_nxt;
            period_tick <= tick_nxt;
            done        <= done_nxt;
            if ((state == ARMED) && (state_nxt == RUN)) begin
                burst_reg   <= burst_len;
                pulses_done <= '0;
            end else if (tick_nxt) begin
                pulses_done <= pulses_inc;
            end
            if (load_cfg) begin
                active_high <= shadow;
                pending     <= 1'b0;
            end else if (cfg_valid && !pending) begin
                shadow  <= cfg_high;
                pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_clock_wave_gen.sv
// Self-checking bench for clock_wave_gen: per-period expectations are queued as
// stimulus is planned and compared as each period of output completes.
module tb_clock_wave_gen;
    localparam int WIDTH   = 32;
    localparam int PULSE_W = 16;
    localparam int PER     = 10;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               enable = 1'b0;
    logic               clear = 1'b0;
    logic               cfg_valid = 1'b0;
    logic [WIDTH-1:0]   counter = '0;
    logic [WIDTH-1:0]   cfg_high = '0;
    logic [PULSE_W-1:0] burst_len = '0;
    logic               cfg_ready, clk_out, period_tick, busy, done;
    logic [PULSE_W-1:0] pulses_done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int high;
        int pulses;
        bit done_end;
        bit busy_end;
        bit ready_end;
        int wr_step;
        int wr_val;
        int drop_step;
    } per_t;
    per_t exp_q[$];

    clock_wave_gen #(.WIDTH(WIDTH), .PULSE_W(PULSE_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .counter(counter), .clear(clear),
        .cfg_high(cfg_high), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .burst_len(burst_len), .clk_out(clk_out), .period_tick(period_tick),
        .busy(busy), .pulses_done(pulses_done), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Upstream model: counter runs 0..PER-1, clear is high while counter is PER-1.
    task automatic step();
        @(posedge clk);
        #1;
        counter = (counter == WIDTH'(PER - 1)) ? '0 : counter + WIDTH'(1);
        clear   = (counter == WIDTH'(PER - 1));
    endtask

    task automatic push_exp(int high, int pulses, bit done_end, bit busy_end, bit ready_end,
                            int wr_step, int wr_val, int drop_step);
        per_t e;
        e.high = high; e.pulses = pulses; e.done_end = done_end; e.busy_end = busy_end;
        e.ready_end = ready_end; e.wr_step = wr_step; e.wr_val = wr_val; e.drop_step = drop_step;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b0; enable = 1'b0; cfg_valid = 1'b0; burst_len = '0;
        step(); step();
        reset = 1'b1;
        step();
    endtask

    task automatic write_cfg(int val);
        cfg_high = WIDTH'(val); cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++; $display("FAIL cfg_capture: cfg_ready=%b want 0", cfg_ready);
        end
    endtask

    // Enables, waits for ARMED, then steps through the first boundary into RUN.
    task automatic arm();
        int k;
        enable = 1'b1;
        k = 0;
        while (busy !== 1'b1 && k < 6) begin step(); k++; end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL arm_busy: busy=%b want 1", busy); end
        k = 0;
        while (clear !== 1'b1 && k < 2 * PER) begin step(); k++; end
        checks++;
        if (clear !== 1'b1) begin errors++; $display("FAIL arm_boundary: no clear within %0d cycles", 2 * PER); end
        step();
    endtask

    task automatic run_periods(int n);
        per_t e;
        int hc, tick_bad, done_bad, ready_bad, want_hc;
        for (int p = 0; p < n; p++) begin
            if (exp_q.size() == 0) begin
                errors++; checks++; $display("FAIL scoreboard_empty: period %0d has no expectation", p);
                return;
            end
            e = exp_q.pop_front();
            hc = 0; tick_bad = 0; done_bad = 0; ready_bad = 0;
            for (int j = 1; j <= PER; j++) begin
                if (j == e.drop_step) enable = 1'b0;
                if (j == e.wr_step) begin cfg_high = WIDTH'(e.wr_val); cfg_valid = 1'b1; end
                step();
                cfg_valid = 1'b0;
                if (clk_out === 1'b1) hc++;
                if (j < PER && period_tick !== 1'b0) tick_bad++;
                if (j < PER && done !== 1'b0) done_bad++;
                if (e.wr_step > 0 && e.wr_step < PER && j >= e.wr_step && j < PER && cfg_ready !== 1'b0)
                    ready_bad++;
            end
            want_hc = (e.high < PER) ? e.high : PER;
            checks++;
            if (hc != want_hc) begin errors++; $display("FAIL high_time p%0d: got %0d want %0d", e.pulses, hc, want_hc); end
            checks++;
            if (period_tick !== 1'b1 || tick_bad != 0) begin
                errors++; $display("FAIL period_tick p%0d: end=%b stray=%0d want end=1 stray=0", e.pulses, period_tick, tick_bad);
            end
            checks++;
            if (pulses_done !== PULSE_W'(e.pulses)) begin
                errors++; $display("FAIL pulses_done: got %0d want %0d", pulses_done, e.pulses);
            end
            checks++;
            if (done !== e.done_end || done_bad != 0) begin
                errors++; $display("FAIL done p%0d: end=%b stray=%0d want end=%b", e.pulses, done, done_bad, e.done_end);
            end
            checks++;
            if (busy !== e.busy_end) begin errors++; $display("FAIL busy_end p%0d: got %b want %b", e.pulses, busy, e.busy_end); end
            checks++;
            if (cfg_ready !== e.ready_end || ready_bad != 0) begin
                errors++; $display("FAIL cfg_ready p%0d: end=%b early=%0d want end=%b", e.pulses, cfg_ready, ready_bad, e.ready_end);
            end
        end
    endtask

    task automatic idle_hold(int n, int want_pulses);
        int bad;
        bad = 0;
        for (int j = 0; j < n; j++) begin
            step();
            if (clk_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || period_tick !== 1'b0 ||
                pulses_done !== PULSE_W'(want_pulses)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL idle_hold: %0d bad cycles, pulses_done=%0d want %0d", bad, pulses_done, want_pulses);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(); step();
        checks++;
        if ({clk_out, period_tick, busy, done, cfg_ready} !== 5'b00001) begin
            errors++; $display("FAIL reset_outputs: {clk_out,tick,busy,done,ready}=%b want 00001",
                               {clk_out, period_tick, busy, done, cfg_ready});
        end
        checks++;
        if (pulses_done !== '0) begin errors++; $display("FAIL reset_pulses: got %0d want 0", pulses_done); end
    endtask

    task automatic test_continuous();
        do_reset();
        write_cfg(4);
        burst_len = '0;
        arm();
        checks++;
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_loaded_at_start: cfg_ready=%b want 1", cfg_ready); end
        push_exp(4, 1, 0, 1, 1, -1, 0, -1);
        push_exp(4, 2, 0, 1, 1, -1, 0, -1);
        push_exp(4, 3, 0, 1, 1, -1, 0, -1);
        run_periods(3);
    endtask

    // Continues the run left by test_continuous.
    task automatic test_cfg_update();
        push_exp(4, 4, 0, 1, 1, 3, 7, -1);
        push_exp(7, 5, 0, 1, 0, PER, 9, -1);
        push_exp(7, 6, 0, 1, 1, -1, 0, -1);
        push_exp(9, 7, 0, 1, 1, -1, 0, -1);
        run_periods(4);
    endtask

    task automatic test_burst();
        do_reset();
        write_cfg(5);
        burst_len = PULSE_W'(3);
        arm();
        push_exp(5, 1, 0, 1, 1, -1, 0, -1);
        push_exp(5, 2, 0, 1, 1, -1, 0, -1);
        push_exp(5, 3, 1, 0, 1, -1, 0, -1);
        run_periods(3);
        enable = 1'b0;
        idle_hold(12, 3);
    endtask

    task automatic test_stop();
        do_reset();
        write_cfg(4);
        burst_len = '0;
        arm();
        push_exp(4, 1, 1, 0, 1, -1, 0, 3);
        run_periods(1);
        idle_hold(12, 1);
    endtask

    task automatic test_extremes();
        do_reset();
        write_cfg(0);
        burst_len = '0;
        arm();
        push_exp(0, 1, 0, 1, 1, -1, 0, -1);
        push_exp(0, 2, 0, 1, 1, 4, 20, -1);
        push_exp(20, 3, 0, 1, 1, -1, 0, -1);
        push_exp(20, 4, 0, 1, 1, -1, 0, -1);
        run_periods(4);
    endtask

    task automatic test_reset_mid();
        do_reset();
        write_cfg(4);
        burst_len = '0;
        arm();
        push_exp(4, 1, 0, 1, 1, -1, 0, -1);
        run_periods(1);
        cfg_high = WIDTH'(7); cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        step();
        checks++;
        if ({clk_out, busy, cfg_ready} !== 3'b110) begin
            errors++; $display("FAIL pre_reset: {clk_out,busy,ready}=%b want 110", {clk_out, busy, cfg_ready});
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({clk_out, period_tick, busy, done, cfg_ready} !== 5'b00001 || pulses_done !== '0) begin
            errors++; $display("FAIL async_reset: {clk_out,tick,busy,done,ready}=%b pulses=%0d want 00001 pulses=0",
                               {clk_out, period_tick, busy, done, cfg_ready}, pulses_done);
        end
        enable = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        checks++;
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", cfg_ready); end
        arm();
        push_exp(0, 1, 0, 1, 1, -1, 0, -1);
        run_periods(1);
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_cfg_update();
        test_burst();
        test_stop();
        test_extremes();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
